// File: rtl/ifu.sv
// ifu: instruction fetch unit for the single-cycle NPC core.
// Owns the program counter and drives it into a combinational instruction
// memory. Each {pc, inst} pair is captured into a 2-entry fetch queue and
// handed to decode over a valid/ready handshake. Redirects from execute
// flush the queue. A misaligned target or an ebreak word halts fetch.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   imem_pc   (out)     fetch address to instruction memory
//   imem_inst (in)      instruction word for imem_pc, same cycle
//   redirect_valid/pc   one-cycle redirect request and its target
//   out_valid/ready     handshake to decode for the queue head
//   out_pc/inst         head entry payload
//   out_misaligned      head entry is a misaligned-fetch fault
//   halted              fetch is stopped until the next redirect or reset
module ifu #(
  parameter logic [31:0] RESET_PC    = 32'h8000_0000,
  parameter logic [31:0] NOP_INST    = 32'h0000_0013,
  parameter logic [31:0] EBREAK_INST = 32'h0010_0073
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_pc,
  input  logic [31:0] imem_inst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic        out_misaligned,
  output logic        halted
);

  localparam int unsigned XLEN   = 32;
  localparam int unsigned QDEPTH = 2;
  localparam int unsigned CNT_W  = 2;

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  logic [0:0]      r_state;
  logic [0:0]      w_state_nxt;
  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] w_fetch_pc_nxt;

  logic [XLEN-1:0] r_q_pc   [QDEPTH];
  logic [XLEN-1:0] r_q_inst [QDEPTH];
  logic            r_q_mis  [QDEPTH];
  logic            r_head;
  logic            r_tail;
  logic [CNT_W-1:0] r_count;

  logic            w_deq;
  logic            w_enq;
  logic            w_misaligned;
  logic            w_ebreak;
  logic [XLEN-1:0] w_enq_inst;

  // Handshake and enqueue qualification; a full queue may still accept
  // when the head leaves in the same cycle.
  assign w_deq        = out_valid & out_ready;
  assign w_enq        = (r_state == ST_RUN) & ~redirect_valid &
                        ((r_count < CNT_W'(QDEPTH)) | w_deq);
  assign w_misaligned = (r_fetch_pc[1:0] != 2'b00);
  assign w_ebreak     = ~w_misaligned & (imem_inst == EBREAK_INST);
  assign w_enq_inst   = w_misaligned ? NOP_INST : imem_inst;

  // Fetch FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_RUN;
      r_fetch_pc <= RESET_PC;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
    end
  end

  // Next state and next fetch address; redirect takes priority over
  // anything the current fetch would have done.
  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    if (redirect_valid) begin
      w_state_nxt    = ST_RUN;
      w_fetch_pc_nxt = redirect_pc;
    end else if (w_enq) begin
      if (w_misaligned) begin
        w_state_nxt = ST_HALT;
      end else begin
        w_fetch_pc_nxt = r_fetch_pc + 32'd4;
        if (w_ebreak) begin
          w_state_nxt = ST_HALT;
        end
      end
    end
  end

  // Fetch queue; a flush only resets pointers, stale storage is never
  // visible because out_valid is low until the next enqueue.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < QDEPTH; i++) begin
        r_q_pc[i]   <= '0;
        r_q_inst[i] <= '0;
        r_q_mis[i]  <= 1'b0;
      end
      r_head  <= 1'b0;
      r_tail  <= 1'b0;
      r_count <= '0;
    end else if (redirect_valid) begin
      r_head  <= 1'b0;
      r_tail  <= 1'b0;
      r_count <= '0;
    end else begin
      if (w_enq) begin
        r_q_pc[r_tail]   <= r_fetch_pc;
        r_q_inst[r_tail] <= w_enq_inst;
        r_q_mis[r_tail]  <= w_misaligned;
        r_tail           <= ~r_tail;
      end
      if (w_deq) begin
        r_head <= ~r_head;
      end
      r_count <= r_count + CNT_W'(w_enq) - CNT_W'(w_deq);
    end
  end

  // All outputs decode directly from registers.
  assign imem_pc        = r_fetch_pc;
  assign out_valid      = (r_count != '0);
  assign out_pc         = r_q_pc[r_head];
  assign out_inst       = r_q_inst[r_head];
  assign out_misaligned = r_q_mis[r_head];
  assign halted         = (r_state == ST_HALT);

endmodule

// File: tb/tb_ifu.sv
module tb_ifu;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] EBREAK   = 32'h0010_0073;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_pc;
  logic [31:0] imem_inst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_misaligned;
  logic        halted;

  ifu dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_pc       (imem_pc),
    .imem_inst     (imem_inst),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pc        (out_pc),
    .out_inst      (out_inst),
    .out_misaligned(out_misaligned),
    .halted        (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: NOP everywhere (or a hash pattern), with one
  // programmable ebreak location.
  logic [31:0] ebreak_addr;
  logic        mem_hash;

  function automatic logic [31:0] mem_fn(input logic [31:0] a, input logic [31:0] eb,
                                         input logic hashed);
    logic [31:0] h;
    if (a == eb) return EBREAK;
    if (!hashed) return NOP;
    h = (a * 32'h9E37_79B1) ^ 32'h5BD1_E995;
    if (h == EBREAK) h = NOP;
    return h;
  endfunction

  assign imem_inst = mem_fn(imem_pc, ebreak_addr, mem_hash);

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a fetch PC, a halt flag and a queue of pending entries.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        mis;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc     = RESET_PC;
  logic        m_halted = 1'b0;

  task automatic model_step(input logic rst, input logic rv, input logic [31:0] rpc,
                            input logic rdy);
    logic        deq;
    logic        can;
    logic [31:0] w;
    if (!rst) begin
      mq.delete();
      m_pc     = RESET_PC;
      m_halted = 1'b0;
    end else begin
      deq = (mq.size() != 0) && rdy;
      if (rv) begin
        mq.delete();
        m_pc     = rpc;
        m_halted = 1'b0;
      end else begin
        can = !m_halted && ((mq.size() < 2) || deq);
        if (deq) void'(mq.pop_front());
        if (can) begin
          if (m_pc[1:0] != 2'b00) begin
            mq.push_back('{pc: m_pc, inst: NOP, mis: 1'b1});
            m_halted = 1'b1;
          end else begin
            w = mem_fn(m_pc, ebreak_addr, mem_hash);
            mq.push_back('{pc: m_pc, inst: w, mis: 1'b0});
            m_pc = m_pc + 32'd4;
            if (w == EBREAK) m_halted = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic check_model();
    chk("m_imem_pc", imem_pc, m_pc);
    chk("m_out_valid", 32'(out_valid), 32'(mq.size() != 0));
    chk("m_halted", 32'(halted), 32'(m_halted));
    if (mq.size() != 0) begin
      chk("m_out_pc", out_pc, mq[0].pc);
      chk("m_out_inst", out_inst, mq[0].inst);
      chk("m_out_mis", 32'(out_misaligned), 32'(mq[0].mis));
    end
  endtask

  // Drive one cycle: inputs set away from the edge, sampled 1 time unit after it.
  task automatic cycle(input logic rst, input logic rv, input logic [31:0] rpc,
                       input logic rdy);
    rst_n          = rst;
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = rdy;
    model_step(rst, rv, rpc, rdy);
    @(posedge clk);
    #1;
    check_model();
  endtask

  typedef struct {
    logic        rst_n;
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
    logic        e_mis;
    logic        e_halt;
    logic [31:0] e_imem;
  } vec_t;

  vec_t vecs[16];

  initial begin : main
    logic        found;
    logic [31:0] rpc;
    ebreak_addr    = 32'h0;
    mem_hash       = 1'b0;
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = 1'b0;

    // Reset release, backpressure, redirect flush.
    vecs[0]  = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0,          32'h0, 1'b0, 1'b0, 32'h8000_0000};
    vecs[1]  = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0,          32'h0, 1'b0, 1'b0, 32'h8000_0000};
    vecs[2]  = '{1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h8000_0000,  NOP,   1'b0, 1'b0, 32'h8000_0004};
    vecs[3]  = '{1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h8000_0004,  NOP,   1'b0, 1'b0, 32'h8000_0008};
    vecs[4]  = '{1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h8000_0008,  NOP,   1'b0, 1'b0, 32'h8000_000C};
    vecs[5]  = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0,          32'h0, 1'b0, 1'b0, 32'h8000_0000};
    vecs[6]  = '{1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h8000_0000,  NOP,   1'b0, 1'b0, 32'h8000_0004};
    vecs[7]  = '{1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h8000_0000,  NOP,   1'b0, 1'b0, 32'h8000_0008};
    vecs[8]  = '{1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h8000_0000,  NOP,   1'b0, 1'b0, 32'h8000_0008};
    vecs[9]  = '{1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h8000_0000,  NOP,   1'b0, 1'b0, 32'h8000_0008};
    vecs[10] = '{1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h8000_0000,  NOP,   1'b0, 1'b0, 32'h8000_0008};
    vecs[11] = '{1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h8000_0004,  NOP,   1'b0, 1'b0, 32'h8000_000C};
    vecs[12] = '{1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h8000_0008,  NOP,   1'b0, 1'b0, 32'h8000_0010};
    vecs[13] = '{1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h8000_000C,  NOP,   1'b0, 1'b0, 32'h8000_0014};
    vecs[14] = '{1'b1, 1'b1, 32'h8000_0100, 1'b0, 1'b0, 32'h0,  32'h0, 1'b0, 1'b0, 32'h8000_0100};
    vecs[15] = '{1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h8000_0100,  NOP,   1'b0, 1'b0, 32'h8000_0104};

    for (int i = 0; i < 16; i++) begin
      cycle(vecs[i].rst_n, vecs[i].rv, vecs[i].rpc, vecs[i].rdy);
      chk("v_imem_pc", imem_pc, vecs[i].e_imem);
      chk("v_out_valid", 32'(out_valid), 32'(vecs[i].e_valid));
      chk("v_halted", 32'(halted), 32'(vecs[i].e_halt));
      if (vecs[i].e_valid || !vecs[i].rst_n) begin
        chk("v_out_pc", out_pc, vecs[i].e_pc);
        chk("v_out_inst", out_inst, vecs[i].e_inst);
        chk("v_out_mis", 32'(out_misaligned), 32'(vecs[i].e_mis));
      end
    end

    // ebreak halt at 8000000C, then redirect resumes.
    ebreak_addr = 32'h8000_000C;
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      cycle(1'b1, 1'b0, 32'h0, 1'b1);
      if (out_valid && out_pc == 32'h8000_000C) found = 1'b1;
    end
    chk("ebreak_seen", 32'(found), 32'd1);
    chk("ebreak_inst", out_inst, EBREAK);
    chk("ebreak_halted", 32'(halted), 32'd1);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b0, 32'h0, 1'b1);
      chk("halt_no_enq", 32'(out_valid), 32'd0);
    end
    chk("halt_imem_pc", imem_pc, 32'h8000_0010);
    cycle(1'b1, 1'b1, 32'h8000_0000, 1'b1);
    chk("resume_halted", 32'(halted), 32'd0);
    cycle(1'b1, 1'b0, 32'h0, 1'b1);
    chk("resume_out_pc", out_pc, 32'h8000_0000);
    chk("resume_valid", 32'(out_valid), 32'd1);
    ebreak_addr = 32'h0;

    // Misaligned redirect target.
    cycle(1'b1, 1'b1, 32'h8000_0102, 1'b0);
    cycle(1'b1, 1'b0, 32'h0, 1'b0);
    chk("mis_out_pc", out_pc, 32'h8000_0102);
    chk("mis_out_inst", out_inst, NOP);
    chk("mis_flag", 32'(out_misaligned), 32'd1);
    chk("mis_halted", 32'(halted), 32'd1);
    chk("mis_imem_pc", imem_pc, 32'h8000_0102);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'h0, 1'b0);
    chk("mis_hold_pc", out_pc, 32'h8000_0102);
    cycle(1'b1, 1'b0, 32'h0, 1'b1);
    chk("mis_single_entry", 32'(out_valid), 32'd0);

    // Redirect with dequeue, then reset mid-stream.
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    cycle(1'b1, 1'b0, 32'h0, 1'b0);
    cycle(1'b1, 1'b0, 32'h0, 1'b0);
    cycle(1'b1, 1'b1, 32'h8000_0200, 1'b1);
    chk("rd_deq_flush", 32'(out_valid), 32'd0);
    chk("rd_deq_imem", imem_pc, 32'h8000_0200);
    cycle(1'b1, 1'b0, 32'h0, 1'b1);
    chk("rd_deq_target", out_pc, 32'h8000_0200);
    cycle(1'b1, 1'b0, 32'h0, 1'b1);
    cycle(1'b1, 1'b0, 32'h0, 1'b1);
    cycle(1'b0, 1'b1, 32'h8000_0300, 1'b1);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_inst", out_inst, 32'h0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_imem", imem_pc, RESET_PC);
    cycle(1'b1, 1'b0, 32'h0, 1'b1);
    chk("rst_restart_pc", out_pc, RESET_PC);
    chk("rst_restart_imem", imem_pc, 32'h8000_0004);

    // Redirect coinciding with an ebreak fetch: redirect wins.
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    ebreak_addr = RESET_PC;
    cycle(1'b1, 1'b1, 32'h8000_0400, 1'b1);
    chk("rd_eb_halted", 32'(halted), 32'd0);
    chk("rd_eb_valid", 32'(out_valid), 32'd0);
    chk("rd_eb_imem", imem_pc, 32'h8000_0400);

    // Randomized run against the model.
    mem_hash    = 1'b1;
    ebreak_addr = 32'h8000_0040;
    for (int i = 0; i < 3000; i++) begin
      rpc = {24'h80_0000, 8'($urandom)};
      if ($urandom_range(3) != 0) rpc[1:0] = 2'b00;
      cycle(($urandom_range(199) != 0), ($urandom_range(15) == 0), rpc,
            ($urandom_range(3) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/ifu.md
# ifu

Instruction fetch unit for the single-cycle NPC core.
- Owns the program counter and drives it into the combinational instruction memory, which returns the instruction word in the same cycle.
- Captures each `{pc, instruction}` pair into a 2-entry fetch queue.
- Presents queue entries to decode over a valid/ready handshake.
- Handles redirects from execute (branches, jumps, traps), misaligned targets, and halting on `ebreak`.

## Interface
Parameters:
- `RESET_PC`, 32'h80000000: first fetch address after reset.
- `NOP_INST`, 32'h00000013: word substituted for a faulted fetch.
- `EBREAK_INST`, 32'h00100073: encoding that halts fetch.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `imem_pc`  out  32  fetch address to instruction memory; always equals the internal `fetch_pc`.
- `imem_inst`  in  32  instruction word from memory, valid in the same cycle as `imem_pc`.
- `redirect_valid`  in  1  one-cycle redirect request from execute.
- `redirect_pc`  in  32  redirect target.
- `out_valid`  out  1  queue head holds a valid entry.
- `out_ready`  in  1  decode accepts the head this cycle.
- `out_pc`  out  32  PC of the head entry.
- `out_inst`  out  32  instruction of the head entry.
- `out_misaligned`  out  1  head entry is a misaligned-fetch fault.
- `halted`  out  1  fetch FSM is in HALT.

## Operation
Fetch queue:
- 2 entries of `{pc[31:0], inst[31:0], misaligned}`.
- 1-bit head pointer, 1-bit tail pointer, 2-bit `count` (0..2).
- Outputs are driven from the head entry; `out_valid = (count != 0)`.
- Dequeue: `deq = out_valid & out_ready`.

Fetch FSM has two states:
- RUN: fetching.
- HALT: not fetching; `halted = 1`.

Enqueue condition:
- `enq = (state == RUN) & ~redirect_valid & ((count < 2) | deq)`.
- An enqueue while full is allowed only when a dequeue happens in the same cycle.

On `enq`:
- Write `{fetch_pc, imem_inst, 0}` at the tail.
- `fetch_pc <= fetch_pc + 32'd4`, wrapping modulo 2^32.
- If `imem_inst == EBREAK_INST`: the entry is still enqueued, and state goes to HALT.

Misaligned fetch:
- Condition: `fetch_pc[1:0] != 0` while in RUN and enqueue is allowed.
- Enqueue `{fetch_pc, NOP_INST, 1}`.
- Do not increment `fetch_pc`.
- State goes to HALT.

Redirect (`redirect_valid = 1`):
- Queue is flushed: `count <= 0`, head and tail pointers reset to 0.
- `fetch_pc <= redirect_pc`.
- State goes to RUN, including from HALT.
- No enqueue occurs that cycle.
- The redirect target is fetched on the following cycle.

HALT:
- Only `redirect_valid` or reset leaves HALT.
- The queue keeps draining normally while halted.

Count update:
- `count <= count + enq - deq` when there is no redirect.

## Timing
Reset (`rst_n = 0` at a rising edge):
- `fetch_pc = RESET_PC`, `count = 0`, pointers = 0, state = RUN.
- All queue storage is cleared to 0.
- Resulting outputs: `out_valid = 0`, `out_pc = 0`, `out_inst = 0`, `out_misaligned = 0`, `halted = 0`.
- `imem_pc = RESET_PC`.
- Reset overrides `redirect_valid` and any handshake in the same cycle.
- Reset mid-operation discards all queued entries.

Latency:
- A fetch at cycle N appears on `out_*` at cycle N+1 (`out_valid` high).

Throughput:
- One instruction per cycle while `out_ready` is held high.
- The queue never exceeds 2 entries.
- `imem_pc` stalls (holds its value) while the queue is full and there is no dequeue.

Simultaneous events:
- Redirect with `deq` in the same cycle: decode's acceptance of the head is honoured, and the queue is still fully flushed.
- Redirect in the same cycle as an `ebreak` or misaligned fetch: the redirect wins; nothing is enqueued and the state is RUN.
- Dequeue of the last entry with no enqueue: `out_valid` falls next cycle.

Outputs and paths:
- `out_*` are stable while `out_valid & ~out_ready`; the head changes only on `deq` or redirect.
- No combinational path from `out_ready` or `redirect_valid` to `imem_pc`.

## Test plan
- **Reset release:**
  - `rst_n` high at cycle 0, `out_ready = 1`, memory returns `0x00000013` everywhere.
  - Required: `imem_pc` = 80000000, 80000004, 80000008 on successive cycles.
  - Required: `out_pc` lags by one cycle; `out_valid` rises at cycle 1.
- **Backpressure:**
  - Hold `out_ready = 0` for 5 cycles.
  - Required: exactly 2 entries accepted (80000000, 80000004); `imem_pc` holds at 80000008.
  - Then raise `out_ready`: entries drain in order and fetch resumes at 80000008 with no gaps or duplicates.
- **Redirect flush:**
  - With 2 entries queued, pulse `redirect_valid` with `redirect_pc = 80000100`.
  - Required: `out_valid = 0` the next cycle, then `out_pc = 80000100` one cycle later.
- **ebreak halt:**
  - Memory returns `0x00100073` at 8000000C.
  - Required: that entry is delivered with `out_inst = 00100073` and `halted = 1`.
  - Required: no further enqueues for 10 cycles.
  - Then a redirect to 80000000 resumes fetch and clears `halted`.
- **Misaligned target:**
  - Redirect to 80000102.
  - Required: a single entry `out_pc = 80000102`, `out_inst = 00000013`, `out_misaligned = 1`, then `halted = 1`.
- **Simultaneous redirect + dequeue + reset mid-run:**
  - Redirect while `out_ready = 1`: the head counts as consumed and the rest of the queue is flushed.
  - Assert `rst_n = 0` for one cycle mid-stream: all outputs return to reset values and fetch restarts at 80000000.
